// File: rtl/clock_set_ctrl.sv
// Timekeeping and manual time-set controller for the digital clock.
// Runs h:m:s from a 1 Hz tick; mode/up/down keys adjust one field at a time.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] set_state,
  output logic       setting
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOUR = 2'd1;
  localparam logic [1:0] ST_MIN  = 2'd2;
  localparam logic [1:0] ST_SEC  = 2'd3;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;
  localparam logic [8:0] TO_LIM   = 9'(TIMEOUT_TICKS);

  logic [1:0] state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [7:0] tcnt_q, tcnt_d;

  logic       any_key;
  logic       adj_up;
  logic       adj_dn;
  logic [8:0] tcnt_inc;

  function automatic logic [4:0] hr_inc(input logic [4:0] v);
    hr_inc = (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] hr_dec(input logic [4:0] v);
    hr_dec = (v == 5'd0) ? HOUR_MAX : v - 5'd1;
  endfunction

  function automatic logic [5:0] ms_inc(input logic [5:0] v);
    ms_inc = (v == MS_MAX) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] ms_dec(input logic [5:0] v);
    ms_dec = (v == 6'd0) ? MS_MAX : v - 6'd1;
  endfunction

  function automatic logic [1:0] next_field(input logic [1:0] s);
    logic [1:0] n;
    n = ST_RUN;
    unique case (s)
      ST_RUN:  n = ST_HOUR;
      ST_HOUR: n = ST_MIN;
      ST_MIN:  n = ST_SEC;
      ST_SEC:  n = ST_RUN;
      default: n = ST_RUN;
    endcase
    return n;
  endfunction

  // mode wins over up/down; up and down together cancel out
  assign any_key  = key_mode | key_up | key_down;
  assign adj_up   = ~key_mode & key_up & ~key_down;
  assign adj_dn   = ~key_mode & key_down & ~key_up;
  assign tcnt_inc = {1'b0, tcnt_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tcnt_d  = tcnt_q;

    if (state_q == ST_RUN) begin
      tcnt_d = 8'd0;
      if (tick_1hz) begin
        sec_d = ms_inc(sec_q);
        if (sec_q == MS_MAX) begin
          min_d = ms_inc(min_q);
          if (min_q == MS_MAX) begin
            hour_d = hr_inc(hour_q);
          end
        end
      end
      if (key_mode) begin
        state_d = ST_HOUR;
      end
    end else begin
      // ticks are dropped while setting; they only feed the idle timeout
      if (any_key) begin
        tcnt_d = 8'd0;
      end else if (tick_1hz) begin
        if (tcnt_inc >= TO_LIM) begin
          state_d = ST_RUN;
          tcnt_d  = 8'd0;
        end else begin
          tcnt_d = tcnt_inc[7:0];
        end
      end

      unique case (1'b1)
        key_mode: state_d = next_field(state_q);
        adj_up: begin
          unique case (state_q)
            ST_HOUR: hour_d = hr_inc(hour_q);
            ST_MIN:  min_d  = ms_inc(min_q);
            default: sec_d  = ms_inc(sec_q);
          endcase
        end
        adj_dn: begin
          unique case (state_q)
            ST_HOUR: hour_d = hr_dec(hour_q);
            ST_MIN:  min_d  = ms_dec(min_q);
            default: sec_d  = ms_dec(sec_q);
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign hour      = hour_q;
  assign min       = min_q;
  assign sec       = sec_q;
  assign set_state = state_q;
  assign setting   = (state_q != ST_RUN);

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Timekeeping and time-set controller for the digital clock.
- Consumes the single-cycle, debounced key pulses produced by the button debouncers (mode, up, down) and a 1 Hz tick.
- Maintains hours/minutes/seconds in binary with a field-select state machine for manual adjustment.
- Outputs feed the display/BCD path downstream.

Parameters:
- TIMEOUT_TICKS, 10, number of 1 Hz ticks with no key activity in a set state before automatic return to RUN; legal range 1..255.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; asynchronous, active-low.
- tick_1hz, input, 1, one-clk-wide pulse once per second.
- key_mode, input, 1, one-clk-wide debounced press pulse; advances field select.
- key_up, input, 1, one-clk-wide debounced press pulse; increments the selected field.
- key_down, input, 1, one-clk-wide debounced press pulse; decrements the selected field.
- hour, output, 5, hours 0..23.
- min, output, 6, minutes 0..59.
- sec, output, 6, seconds 0..59.
- set_state, output, 2, 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
- setting, output, 1, high whenever set_state != RUN; used by the display to blink the field.

Behaviour:
- Reset (rst low, async): hour=0, min=0, sec=0, set_state=RUN, setting=0, timeout counter=0. All outputs registered; changes are visible the clk edge after the causing pulse (latency 1).
- FSM transitions on key_mode: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
- The timeout counter clears on every transition and on any key pulse.
- RUN:
  - On tick_1hz, sec increments.
  - sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0.
  - key_up and key_down are ignored in RUN.
- Set states:
  - Time does not advance; tick_1hz pulses are discarded, with no catch-up later.
  - key_up increments only the selected field with wrap (hour 23->0, min/sec 59->0). No carry into other fields.
  - key_down decrements only the selected field with wrap (hour 0->23, min/sec 0->59). No borrow.
- Timeout in set states:
  - Each tick_1hz with no key pulse in the same cycle increments the timeout counter.
  - When the counter reaches TIMEOUT_TICKS, the FSM goes to RUN on that cycle and the counter clears.
  - The field values entered so far are kept.
- Priority and simultaneous events:
  - key_mode beats key_up/key_down: in the same cycle the FSM advances and the field is not modified.
  - key_up with key_down in the same cycle: no field change, but the timeout counter still clears.
  - A key pulse in the same cycle as the timeout-reaching tick: the key is processed and the timeout is cancelled.
  - key_mode in RUN with tick_1hz in the same cycle: the tick is processed (time advances), then the state becomes SET_HOUR.
- Exit to RUN (via key_mode or timeout): counting resumes on the next tick_1hz with the current values.
- Reset mid-operation forces the full reset state regardless of FSM state.
- Out-of-range values are unreachable; the counters never hold hour>23 or min/sec>59.
- Width rules: compare before increment; no reliance on natural overflow of the 5/6-bit registers.

Test Plan:
- Reset, then 61 tick_1hz pulses -> hour=0, min=1, sec=1, set_state=0.
- Preload 23:59:59 via set keys, return to RUN, one tick -> 00:00:00; with sec=59 and min=59 a single tick increments hour exactly once.
- key_mode once, key_down once at hour=0 -> hour=23, min/sec unchanged, setting=1; key_mode x3 more -> set_state=0, setting=0.
- In SET_MIN at min=59: key_up -> min=0, hour unchanged; key_up and key_down in the same cycle -> min stays 0; key_mode with key_up in the same cycle -> set_state=3, min stays 0.
- In SET_SEC with no keys: 9 ticks -> still set_state=3; 10th tick -> set_state=0. Repeat with key_up on tick 5 -> return occurs only on the 15th tick, and sec has incremented by 1.
- Assert rst low while in SET_MIN at 12:34:56 -> outputs immediately 0:0:0, set_state=0; after release, the first tick -> sec=1.
